// File: rtl/video_sync_shift.sv
// Sync re-centring stage: delays pixel/blank by one ce_pix and regenerates HSYNC/VSYNC
// with signed offsets once each axis has learned a stable sync geometry.

module video_sync_shift_axis #(
  parameter int CW      = 9,
  parameter int MIN_GAP = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic       step_i,
  input  logic       boundary_i,
  input  logic       blank_fall_i,
  input  logic       off_strobe_i,
  input  logic [3:0] off_i,
  input  logic       sync_n_i,
  output logic       sync_n_o,
  output logic       lock_o
);

  typedef enum logic {LEARN = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [CW-1:0]        CNT_MAX = '1;
  localparam logic signed [CW+1:0] GAP     = (CW+2)'(MIN_GAP);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] s_acc_q, s_acc_d, w_acc_q, w_acc_d, b_acc_q, b_acc_d;
  logic [CW-1:0] s_ref_q, s_ref_d, w_ref_q, w_ref_d, b_ref_q, b_ref_d;
  logic          edge_q, edge_d, sat_q, sat_d;
  logic          started_q, started_d, ref_valid_q, ref_valid_d;
  logic          sync_prev_q, sync_n_q, sync_n_d;
  logic [3:0]    off_q, off_d;
  logic          sync_fall, period_ok, match, shift_sel, no_room, in_win;
  logic signed [CW+1:0] t_raw, t_hi, t_sel, s_s, w_s, b_s, cnt_s;

  assign sync_fall = sync_prev_q & ~sync_n_i;
  assign period_ok = started_q & edge_q & ~sat_q;
  assign match     = period_ok & ref_valid_q &
                     (s_acc_q == s_ref_q) & (w_acc_q == w_ref_q) & (b_acc_q == b_ref_q);

  // Measurement: the sample that opens a period belongs to the new period.
  always_comb begin
    cnt_d       = cnt_q;
    s_acc_d     = s_acc_q;
    w_acc_d     = w_acc_q;
    b_acc_d     = b_acc_q;
    s_ref_d     = s_ref_q;
    w_ref_d     = w_ref_q;
    b_ref_d     = b_ref_q;
    edge_d      = edge_q;
    sat_d       = sat_q;
    started_d   = started_q;
    ref_valid_d = ref_valid_q;
    if (boundary_i) begin
      cnt_d       = '0;
      s_ref_d     = s_acc_q;
      w_ref_d     = w_acc_q;
      b_ref_d     = b_acc_q;
      ref_valid_d = period_ok;
      started_d   = 1'b1;
      s_acc_d     = '0;
      w_acc_d     = '0;
      b_acc_d     = '0;
      edge_d      = 1'b0;
      sat_d       = 1'b0;
    end else if (step_i) begin
      if (cnt_q == CNT_MAX) sat_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end
    if (sync_fall) begin
      s_acc_d = cnt_d;
      edge_d  = 1'b1;
    end
    if (step_i && !sync_n_i && (w_acc_d != CNT_MAX)) w_acc_d = w_acc_d + 1'b1;
    if (blank_fall_i) b_acc_d = cnt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      s_acc_q     <= '0;
      w_acc_q     <= '0;
      b_acc_q     <= '0;
      s_ref_q     <= '0;
      w_ref_q     <= '0;
      b_ref_q     <= '0;
      edge_q      <= 1'b0;
      sat_q       <= 1'b0;
      started_q   <= 1'b0;
      ref_valid_q <= 1'b0;
      sync_prev_q <= 1'b1;
      sync_n_q    <= 1'b1;
      off_q       <= '0;
    end else if (ce_i) begin
      cnt_q       <= cnt_d;
      s_acc_q     <= s_acc_d;
      w_acc_q     <= w_acc_d;
      b_acc_q     <= b_acc_d;
      s_ref_q     <= s_ref_d;
      w_ref_q     <= w_ref_d;
      b_ref_q     <= b_ref_d;
      edge_q      <= edge_d;
      sat_q       <= sat_d;
      started_q   <= started_d;
      ref_valid_q <= ref_valid_d;
      sync_prev_q <= sync_n_i;
      sync_n_q    <= sync_n_d;
      off_q       <= off_d;
    end
  end

  // Mode FSM: state register, next state, output select.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   state_q <= LEARN;
    else if (ce_i) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (boundary_i) state_d = match ? LOCK : LEARN;
  end

  // The new mode applies from the boundary sample itself, so a switch never cuts a pulse.
  always_comb begin
    shift_sel = (state_d == LOCK);
  end

  // Shifted window from the previous period's geometry and the offset latched at the boundary.
  assign off_d = off_strobe_i ? off_i : off_q;
  assign s_s   = {2'b00, s_ref_d};
  assign w_s   = {2'b00, w_ref_d};
  assign b_s   = {2'b00, b_ref_d};
  assign cnt_s = {2'b00, cnt_d};
  assign t_raw = s_s + {{(CW-2){off_d[3]}}, off_d};
  assign t_hi  = b_s - w_s - GAP;
  assign no_room = b_s < (w_s + GAP + GAP);

  always_comb begin
    t_sel = t_raw;
    if (no_room)          t_sel = s_s;
    else if (t_raw < GAP) t_sel = GAP;
    else if (t_raw > t_hi) t_sel = t_hi;
  end

  assign in_win   = (cnt_s >= t_sel) && (cnt_s < (t_sel + w_s));
  assign sync_n_d = shift_sel ? ~in_win : sync_n_i;
  assign sync_n_o = sync_n_q;
  assign lock_o   = shift_sel;

endmodule

module video_sync_shift #(
  parameter int HCW     = 9,
  parameter int VCW     = 9,
  parameter int MIN_GAP = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic [3:0]  h_off,
  input  logic [3:0]  v_off,
  input  logic [11:0] rgb_in,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic        hsync_n_in,
  input  logic        vsync_n_in,
  output logic [11:0] rgb_out,
  output logic        hblank_out,
  output logic        vblank_out,
  output logic        hsync_n_out,
  output logic        vsync_n_out,
  output logic        locked
);

  logic [11:0] rgb_q;
  logic        hblank_q, vblank_q, locked_q;
  logic        hblank_prev_q, vblank_prev_q, vb_pend_q, vb_pend_d;
  logic        hb_rise, hb_fall, vb_rise, vb_fall, frame_start;
  logic [1:0]  step_a, boundary_a, blank_fall_a, off_strobe_a, sync_in_a, sync_out_a, lock_a;
  logic [3:0]  off_a [2];

  assign hb_rise = ce_pix & hblank_in & ~hblank_prev_q;
  assign hb_fall = ce_pix & ~hblank_in & hblank_prev_q;
  assign vb_rise = ce_pix & vblank_in & ~vblank_prev_q;
  assign vb_fall = ce_pix & ~vblank_in & vblank_prev_q;
  // A frame starts on the line start coincident with, or first after, the vblank rise.
  assign frame_start = hb_rise & (vb_pend_q | vb_rise);

  always_comb begin
    vb_pend_d = vb_pend_q;
    if (frame_start)  vb_pend_d = 1'b0;
    else if (vb_rise) vb_pend_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q         <= '0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      locked_q      <= 1'b0;
      hblank_prev_q <= 1'b0;
      vblank_prev_q <= 1'b0;
      vb_pend_q     <= 1'b0;
    end else if (ce_pix) begin
      rgb_q         <= rgb_in;
      hblank_q      <= hblank_in;
      vblank_q      <= vblank_in;
      locked_q      <= lock_a[0] & lock_a[1];
      hblank_prev_q <= hblank_in;
      vblank_prev_q <= vblank_in;
      vb_pend_q     <= vb_pend_d;
    end
  end

  // Index 0 is the horizontal axis (pixel units), index 1 the vertical axis (line units).
  assign step_a       = {hb_rise, ce_pix};
  assign boundary_a   = {frame_start, hb_rise};
  assign blank_fall_a = {vb_fall, hb_fall};
  assign off_strobe_a = {vb_rise, hb_rise};
  assign sync_in_a    = {vsync_n_in, hsync_n_in};
  assign off_a[0]     = h_off;
  assign off_a[1]     = v_off;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int CW = (gi == 0) ? HCW : VCW;
      video_sync_shift_axis #(
        .CW      (CW),
        .MIN_GAP (MIN_GAP)
      ) u_axis (
        .clk_i        (clk_sys),
        .rst_ni       (reset_n),
        .ce_i         (ce_pix),
        .step_i       (step_a[gi]),
        .boundary_i   (boundary_a[gi]),
        .blank_fall_i (blank_fall_a[gi]),
        .off_strobe_i (off_strobe_a[gi]),
        .off_i        (off_a[gi]),
        .sync_n_i     (sync_in_a[gi]),
        .sync_n_o     (sync_out_a[gi]),
        .lock_o       (lock_a[gi])
      );
    end
  endgenerate

  assign rgb_out     = rgb_q;
  assign hblank_out  = hblank_q;
  assign vblank_out  = vblank_q;
  assign hsync_n_out = sync_out_a[0];
  assign vsync_n_out = sync_out_a[1];
  assign locked      = locked_q;

endmodule

// File: tb/tb_video_sync_shift.sv
// Directed bench for video_sync_shift: lock timing, offsets, clamping, vertical lock/unlock, reset.

module tb_video_sync_shift;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix = 1'b0;
  logic [3:0]  h_off = 4'h0;
  logic [3:0]  v_off = 4'h0;
  logic [11:0] rgb_in = 12'h000;
  logic        hblank_in = 1'b0, vblank_in = 1'b0, hsync_n_in = 1'b1, vsync_n_in = 1'b1;
  logic [11:0] rgb_out;
  logic        hblank_out, vblank_out, hsync_n_out, vsync_n_out, locked;

  int          n_cmp = 0, n_bad = 0, line_no = 0;
  int          hs_start, hs_len, dp_err;
  logic [11:0] dp_act, dp_exp, last_rgb;
  logic        vs_at_start, lock_mid;
  logic        vs_line [14];

  video_sync_shift dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ce_pix      (ce_pix),
    .h_off       (h_off),
    .v_off       (v_off),
    .rgb_in      (rgb_in),
    .hblank_in   (hblank_in),
    .vblank_in   (vblank_in),
    .hsync_n_in  (hsync_n_in),
    .vsync_n_in  (vsync_n_in),
    .rgb_out     (rgb_out),
    .hblank_out  (hblank_out),
    .vblank_out  (vblank_out),
    .hsync_n_out (hsync_n_out),
    .vsync_n_out (vsync_n_out),
    .locked      (locked)
  );

  always #5 clk_sys = ~clk_sys;

  // One video line (or its first n_samp pixels); records where hsync_n_out is low.
  task automatic run_line(input int b, input int s, input int w, input logic vb, input logic vs,
                          input int n_samp, input int chg_hc, input logic [3:0] chg_val);
    logic [11:0] exp_rgb;
    hs_start = -1;
    hs_len   = 0;
    for (int hc = 0; hc < n_samp; hc++) begin
      @(negedge clk_sys);
      if (hc == chg_hc) h_off = chg_val;
      ce_pix     = 1'b1;
      hblank_in  = (hc < b);
      hsync_n_in = !((hc >= s) && (hc < s + w));
      vblank_in  = vb;
      vsync_n_in = !vs;
      exp_rgb    = 12'(line_no * 131 + hc * 7);
      rgb_in     = exp_rgb;
      @(posedge clk_sys);
      #1;
      if ((rgb_out !== exp_rgb) || (hblank_out !== hblank_in) || (vblank_out !== vblank_in)) begin
        if (dp_err == 0) begin
          dp_act = rgb_out;
          dp_exp = exp_rgb;
        end
        dp_err++;
      end
      if (hsync_n_out === 1'b0) begin
        if (hs_start < 0) hs_start = hc;
        hs_len++;
      end
      if (hc == 0)  vs_at_start = vsync_n_out;
      if (hc == 40) lock_mid = locked;
      last_rgb = exp_rgb;
    end
    line_no++;
  endtask

  task automatic run_frame(input int wv, output int vstart, output int vlen, output logic lk);
    vstart = -1;
    vlen   = 0;
    lk     = 1'bx;
    for (int ln = 0; ln < 14; ln++) begin
      run_line(56, 23, 31, (ln < 10), ((ln >= 3) && (ln < 3 + wv)), 80, -1, 4'h0);
      vs_line[ln] = vs_at_start;
      if (ln == 5) lk = lock_mid;
    end
    for (int ln = 0; ln < 14; ln++) begin
      if (vs_line[ln] === 1'b0) begin
        if (vstart < 0) vstart = ln;
        vlen++;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    ce_pix = 1'b1; rgb_in = 12'hFFF; hblank_in = 1'b0; vblank_in = 1'b0;
    hsync_n_in = 1'b0; vsync_n_in = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    n_cmp++; if (rgb_out !== 12'h000) begin n_bad++; $display("FAIL reset rgb_out: got %h want 000", rgb_out); end
    n_cmp++; if (hblank_out !== 1'b1) begin n_bad++; $display("FAIL reset hblank_out: got %b want 1", hblank_out); end
    n_cmp++; if (vblank_out !== 1'b1) begin n_bad++; $display("FAIL reset vblank_out: got %b want 1", vblank_out); end
    n_cmp++; if (hsync_n_out !== 1'b1) begin n_bad++; $display("FAIL reset hsync_n_out: got %b want 1", hsync_n_out); end
    n_cmp++; if (vsync_n_out !== 1'b1) begin n_bad++; $display("FAIL reset vsync_n_out: got %b want 1", vsync_n_out); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset locked: got %b want 0", locked); end
    $display("reset: outputs rgb=%h hb=%b vb=%b hs=%b vs=%b lk=%b", rgb_out, hblank_out, vblank_out,
             hsync_n_out, vsync_n_out, locked);
    @(negedge clk_sys);
    ce_pix = 1'b0; hsync_n_in = 1'b1; vsync_n_in = 1'b1;
    reset_n = 1'b1;
  endtask

  // Lines 1-2 learn, line 3 locked with zero offset (identical to passthrough).
  task automatic test_lock_passthrough;
    dp_err = 0;
    for (int i = 0; i < 3; i++) begin
      run_line(64, 23, 31, 1'b0, 1'b0, 80, (i == 2) ? 40 : -1, 4'h7);
      n_cmp++;
      if (hs_start !== 23 || hs_len !== 31) begin
        n_bad++;
        $display("FAIL lock line %0d: hsync low hc %0d len %0d, want hc 23 len 31", i + 1, hs_start, hs_len);
      end else $display("lock line %0d: hsync_n_out low from hc %0d for %0d", i + 1, hs_start, hs_len);
    end
    n_cmp++;
    if (dp_err !== 0) begin
      n_bad++;
      $display("FAIL lock datapath: %0d bad samples, first rgb_out %h want %h", dp_err, dp_act, dp_exp);
    end
  endtask

  task automatic test_h_offsets;
    int exp_s [2] = '{30, 15};
    logic [3:0] nxt [2] = '{4'h8, 4'h5};
    for (int i = 0; i < 2; i++) begin
      run_line(64, 23, 31, 1'b0, 1'b0, 80, 70, nxt[i]);
      n_cmp++;
      if (hs_start !== exp_s[i] || hs_len !== 31) begin
        n_bad++;
        $display("FAIL h_offset step %0d: hsync low hc %0d len %0d, want hc %0d len 31", i, hs_start, hs_len, exp_s[i]);
      end else $display("h_offset step %0d: hsync_n_out low from hc %0d for %0d", i, hs_start, hs_len);
    end
  endtask

  // B drops to 56: one line on old geometry, relearn line, then clamped target 24.
  task automatic test_clamp;
    int exp_s [4] = '{28, 23, 24, 24};
    dp_err = 0;
    for (int i = 0; i < 4; i++) begin
      run_line(56, 23, 31, 1'b0, 1'b0, 80, -1, 4'h0);
      n_cmp++;
      if (hs_start !== exp_s[i] || hs_len !== 31) begin
        n_bad++;
        $display("FAIL clamp line %0d: hsync low hc %0d len %0d, want hc %0d len 31", i, hs_start, hs_len, exp_s[i]);
      end else $display("clamp line %0d: hsync_n_out low from hc %0d for %0d", i, hs_start, hs_len);
    end
    n_cmp++;
    if (dp_err !== 0) begin
      n_bad++;
      $display("FAIL clamp datapath: %0d bad samples, first rgb_out %h want %h", dp_err, dp_act, dp_exp);
    end
  endtask

  task automatic test_vertical;
    int   wv_t [6] = '{7, 7, 7, 6, 7, 7};
    int   vs_t [6] = '{3, 3, 2, 2, 3, 3};
    logic lk_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int   vstart, vlen;
    logic lk;
    v_off = 4'h2;
    for (int f = 0; f < 6; f++) begin
      run_frame(wv_t[f], vstart, vlen, lk);
      n_cmp++;
      if (vstart !== vs_t[f] || vlen !== 7) begin
        n_bad++;
        $display("FAIL vertical frame %0d: vsync low line %0d len %0d, want line %0d len 7", f + 1, vstart, vlen, vs_t[f]);
      end
      n_cmp++;
      if (lk !== lk_t[f]) begin
        n_bad++;
        $display("FAIL vertical frame %0d locked: got %b want %b", f + 1, lk, lk_t[f]);
      end
      $display("vertical frame %0d: vsync_n_out low from line %0d for %0d, locked %b", f + 1, vstart, vlen, lk);
    end
  endtask

  task automatic test_reset_mid_line;
    int exp_s [3] = '{23, 23, 30};
    for (int ln = 0; ln < 5; ln++)
      run_line(56, 23, 31, 1'b1, ((ln >= 3) && (ln < 10)), 80, -1, 4'h0);
    n_cmp++;
    if (lock_mid !== 1'b1) begin n_bad++; $display("FAIL relock before reset: locked %b want 1", lock_mid); end
    run_line(56, 23, 31, 1'b1, 1'b1, 30, -1, 4'h0);
    n_cmp++;
    if (hsync_n_out !== 1'b0) begin n_bad++; $display("FAIL pre-reset hsync at hc 29: got %b want 0", hsync_n_out); end
    @(negedge clk_sys);
    reset_n = 1'b0;
    ce_pix  = 1'b0;
    #1;
    n_cmp++; if (rgb_out !== 12'h000) begin n_bad++; $display("FAIL midreset rgb_out: got %h want 000", rgb_out); end
    n_cmp++; if (hblank_out !== 1'b1) begin n_bad++; $display("FAIL midreset hblank_out: got %b want 1", hblank_out); end
    n_cmp++; if (vblank_out !== 1'b1) begin n_bad++; $display("FAIL midreset vblank_out: got %b want 1", vblank_out); end
    n_cmp++; if (hsync_n_out !== 1'b1) begin n_bad++; $display("FAIL midreset hsync_n_out: got %b want 1", hsync_n_out); end
    n_cmp++; if (vsync_n_out !== 1'b1) begin n_bad++; $display("FAIL midreset vsync_n_out: got %b want 1", vsync_n_out); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL midreset locked: got %b want 0", locked); end
    $display("mid-line reset: outputs rgb=%h hs=%b vs=%b lk=%b", rgb_out, hsync_n_out, vsync_n_out, locked);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    h_off   = 4'h7;
    for (int i = 0; i < 3; i++) begin
      run_line(64, 23, 31, 1'b0, 1'b0, 80, -1, 4'h0);
      n_cmp++;
      if (hs_start !== exp_s[i] || hs_len !== 31) begin
        n_bad++;
        $display("FAIL relearn line %0d: hsync low hc %0d len %0d, want hc %0d len 31", i + 1, hs_start, hs_len, exp_s[i]);
      end else $display("relearn line %0d: hsync_n_out low from hc %0d for %0d", i + 1, hs_start, hs_len);
    end
  endtask

  task automatic test_ce_hold;
    logic h_prev, hb_prev;
    h_prev  = hsync_n_out;
    hb_prev = hblank_out;
    @(negedge clk_sys);
    ce_pix     = 1'b0;
    rgb_in     = ~last_rgb;
    hblank_in  = ~hblank_in;
    hsync_n_in = ~hsync_n_in;
    repeat (3) @(posedge clk_sys);
    #1;
    n_cmp++; if (rgb_out !== last_rgb) begin n_bad++; $display("FAIL ce hold rgb_out: got %h want %h", rgb_out, last_rgb); end
    n_cmp++; if (hblank_out !== hb_prev) begin n_bad++; $display("FAIL ce hold hblank_out: got %b want %b", hblank_out, hb_prev); end
    n_cmp++; if (hsync_n_out !== h_prev) begin n_bad++; $display("FAIL ce hold hsync_n_out: got %b want %b", hsync_n_out, h_prev); end
    $display("ce hold: rgb_out %h held for 3 clocks", rgb_out);
  endtask

  initial begin
    test_reset;
    test_lock_passthrough;
    test_h_offsets;
    test_clamp;
    test_vertical;
    test_reset_mid_line;
    test_ce_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
